// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to DMA_REG halts the CPU and copies one
// 256-byte page to OAM_DATA as alternating read/write bus cycles.
module oam_dma #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_DATA = 16'h2004
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t     state_r, state_s;
  logic       parity_r;
  logic [7:0] page_r, page_s;
  logic [7:0] idx_r, idx_s;
  logic [7:0] latch_r, latch_s;

  // State, cycle parity and transfer datapath registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r  <= IDLE;
      parity_r <= 1'b0;
      page_r   <= 8'h00;
      idx_r    <= 8'h00;
      latch_r  <= 8'h00;
    end else begin
      state_r  <= state_s;
      parity_r <= ~parity_r;
      page_r   <= page_s;
      idx_r    <= idx_s;
      latch_r  <= latch_s;
    end
  end

  // Next-state logic, datapath updates and bus ownership mux
  always_comb begin
    state_s    = state_r;
    page_s     = page_r;
    idx_s      = idx_r;
    latch_s    = latch_r;
    cpu_rdy    = 1'b0;
    dma_active = 1'b1;
    bus_addr   = {page_r, 8'h00};
    bus_wdata  = 8'h00;
    bus_we     = 1'b0;
    case (state_r)
      IDLE: begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        bus_addr   = cpu_addr;
        bus_wdata  = cpu_wdata;
        bus_we     = cpu_we;
        if (cpu_we && (cpu_addr == DMA_REG)) begin
          page_s  = cpu_wdata;
          idx_s   = 8'h00;
          state_s = HALT;
        end else begin
          state_s = IDLE;
        end
      end
      HALT: begin
        // Reads must land on even cycles; an even HALT needs one filler cycle.
        if (parity_r) begin
          state_s = READ;
        end else begin
          state_s = ALIGN;
        end
      end
      ALIGN: begin
        state_s = READ;
      end
      READ: begin
        bus_addr = {page_r, idx_r};
        latch_s  = bus_rdata;
        state_s  = WRITE;
      end
      WRITE: begin
        bus_addr  = OAM_DATA;
        bus_wdata = latch_r;
        bus_we    = 1'b1;
        idx_s     = idx_r + 8'd1;
        if (idx_r == 8'hFF) begin
          state_s = IDLE;
        end else begin
          state_s = READ;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: a transfer-schedule model predicts every bus
// cycle, and a few literal expectations pin lengths and known bytes.
module tb_oam_dma;

  logic        clk;
  logic        n_reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic [7:0]  bus_rdata;
  logic        dma_active;

  logic [7:0]  mem [0:65535];

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data;
  } bus_t;

  bus_t       sched[$];
  bus_t       e;
  logic [7:0] oam_log[$];
  logic [7:0] pg;
  logic       par;
  int         low_total;
  int         scyc;
  int         checks;
  int         errors;

  oam_dma #(.DMA_REG(16'h4014), .OAM_DATA(16'h2004)) dut (
    .clk(clk), .n_reset(n_reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_rdy(cpu_rdy), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_rdata(bus_rdata), .dma_active(dma_active)
  );

  assign bus_rdata = mem[bus_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each transfer expands into a fixed list of expected bus cycles
  initial begin
    par = 1'b0;
    low_total = 0;
    forever begin
      @(negedge clk);
      if (!n_reset) begin
        sched.delete();
        par = 1'b0;
        check("reset_rdy", 32'(cpu_rdy), 32'd1);
        check("reset_active", 32'(dma_active), 32'd0);
        check("reset_addr", 32'(bus_addr), 32'(cpu_addr));
      end else begin
        if (!cpu_rdy) low_total++;
        if (dma_active && bus_we && bus_addr == 16'h2004) oam_log.push_back(bus_wdata);
        if (sched.size() > 0) begin
          e = sched.pop_front();
          check("dma_rdy", 32'(cpu_rdy), 32'd0);
          check("dma_active", 32'(dma_active), 32'd1);
          check("dma_addr", 32'(bus_addr), 32'(e.addr));
          check("dma_we", 32'(bus_we), 32'(e.we));
          if (e.we) check("dma_wdata", 32'(bus_wdata), 32'(e.data));
        end else begin
          check("idle_rdy", 32'(cpu_rdy), 32'd1);
          check("idle_active", 32'(dma_active), 32'd0);
          check("idle_addr", 32'(bus_addr), 32'(cpu_addr));
          check("idle_we", 32'(bus_we), 32'(cpu_we));
          check("idle_wdata", 32'(bus_wdata), 32'(cpu_wdata));
          if (cpu_we && cpu_addr == 16'h4014) begin
            pg = cpu_wdata;
            e = '{addr: {pg, 8'h00}, we: 1'b0, data: 8'h00};
            sched.push_back(e);
            // The halt cycle is the next one; if it is even, one more filler cycle follows.
            if (par) sched.push_back(e);
            for (int k = 0; k < 256; k++) begin
              e = '{addr: {pg, 8'(k)}, we: 1'b0, data: 8'h00};
              sched.push_back(e);
              e = '{addr: 16'h2004, we: 1'b1, data: mem[{pg, 8'(k)}]};
              sched.push_back(e);
            end
          end
        end
        par = ~par;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    scyc++;
  endtask

  task automatic idle_drive();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == 16'h4014) a = 16'h4015;
    cpu_addr  = a;
    cpu_we    = 1'($urandom);
    cpu_wdata = 8'($urandom);
  endtask

  task automatic halted_drive();
    if ($urandom_range(0, 1) == 1) begin
      cpu_addr  = 16'h4014;
      cpu_we    = 1'b1;
      cpu_wdata = 8'h05;
    end else begin
      idle_drive();
    end
  endtask

  task automatic do_trigger(input logic [7:0] page, input logic p);
    while (scyc[0] != p) begin
      idle_drive();
      tick();
    end
    cpu_addr  = 16'h4014;
    cpu_we    = 1'b1;
    cpu_wdata = page;
    tick();
    check("halt_rdy_low", 32'(cpu_rdy), 32'd0);
  endtask

  task automatic run_transfer(input logic [7:0] page, input logic p, input int exp_low,
                              output int n0);
    int lo0;
    int guard;
    lo0 = low_total;
    n0 = oam_log.size();
    do_trigger(page, p);
    guard = 0;
    while (!cpu_rdy && guard < 600) begin
      halted_drive();
      tick();
      guard++;
    end
    idle_drive();
    check("transfer_timeout", 32'(guard < 600), 32'd1);
    check("rdy_low_cycles", 32'(low_total - lo0), 32'(exp_low));
    check("transfer_len", 32'(oam_log.size() - n0), 32'd256);
  endtask

  initial begin
    int n0;
    int guard;
    logic p;
    logic [7:0] rp;
    checks = 0;
    errors = 0;
    scyc = 0;
    n_reset = 1'b0;
    cpu_addr = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_we = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'h0200] = 8'h11;
    mem[16'h02FF] = 8'hEE;
    mem[16'hFF00] = 8'hA5;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'hFF;

    repeat (3) begin
      idle_drive();
      tick();
    end
    #1;
    n_reset = 1'b1;
    scyc = 0;

    // Ordinary register writes in idle pass straight through
    for (int i = 0; i < 6; i++) begin
      cpu_we = 1'b1;
      cpu_addr = (i % 2 == 1) ? 16'h4015 : 16'h2004;
      cpu_wdata = 8'($urandom);
      #1;
      check("pass_addr", 32'(bus_addr), (i % 2 == 1) ? 32'h4015 : 32'h2004);
      check("pass_we", 32'(bus_we), 32'd1);
      check("pass_rdy", 32'(cpu_rdy), 32'd1);
      tick();
    end

    run_transfer(8'h02, 1'b0, 513, n0);
    if (oam_log.size() >= n0 + 256) begin
      check("p02_first", 32'(oam_log[n0]), 32'h11);
      check("p02_last", 32'(oam_log[n0 + 255]), 32'hEE);
    end

    rp = 8'($urandom_range(0, 254));
    run_transfer(rp, 1'b1, 514, n0);

    p = 1'($urandom);
    run_transfer(8'hFF, p, p ? 514 : 513, n0);
    if (oam_log.size() >= n0 + 256) begin
      check("rom_first", 32'(oam_log[n0]), 32'hA5);
      check("rom_second", 32'(oam_log[n0 + 1]), 32'(mem[16'hFF01]));
      check("rom_vec_lo", 32'(oam_log[n0 + 252]), 32'h00);
      check("rom_vec_hi", 32'(oam_log[n0 + 253]), 32'hFF);
    end

    // Abort a transfer by reset after the 100th OAM write
    n0 = oam_log.size();
    do_trigger(8'h07, 1'($urandom));
    guard = 0;
    while (oam_log.size() - n0 < 100 && guard < 400) begin
      halted_drive();
      tick();
      guard++;
    end
    #1;
    n_reset = 1'b0;
    #1;
    check("abort_rdy", 32'(cpu_rdy), 32'd1);
    check("abort_active", 32'(dma_active), 32'd0);
    idle_drive();
    repeat (3) tick();
    #1;
    n_reset = 1'b1;
    scyc = 0;
    repeat (20) begin
      idle_drive();
      tick();
    end
    check("abort_writes", 32'(oam_log.size() - n0), 32'd100);
    run_transfer(8'h07, 1'b0, 513, n0);
    if (oam_log.size() >= n0 + 256) begin
      check("restart_first", 32'(oam_log[n0]), 32'(mem[16'h0700]));
    end

    repeat (2) begin
      p = 1'($urandom);
      run_transfer(8'($urandom), p, p ? 514 : 513, n0);
      repeat (5) begin
        idle_drive();
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter DMA_REG, default 16'h4014, the CPU write address that triggers a transfer.
REQ-002 SHALL have parameter OAM_DATA, default 16'h2004, the destination address written once per byte.
REQ-003 SHALL have port clk, input, 1, system clock, one CPU cycle per rising edge.
REQ-004 SHALL have port n_reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cpu_addr, input, 16, CPU bus address.
REQ-006 SHALL have port cpu_wdata, input, 8, CPU write data.
REQ-007 SHALL have port cpu_we, input, 1, CPU write strobe.
REQ-008 SHALL have port cpu_rdy, output, 1, CPU ready; low halts the CPU.
REQ-009 SHALL have port bus_addr, output, 16, shared system bus address.
REQ-010 SHALL have port bus_wdata, output, 8, shared bus write data.
REQ-011 SHALL have port bus_we, output, 1, shared bus write strobe.
REQ-012 SHALL have port bus_rdata, input, 8, shared bus read data from ROM, RAM or peripherals.
REQ-013 SHALL have port dma_active, output, 1, high while the DMA owns the bus.

Function
REQ-014 SHALL toggle a parity flop every clk; parity 0 is an "even" cycle.
REQ-015 SHALL implement states IDLE, HALT, ALIGN, READ and WRITE.
REQ-016 In IDLE, bus outputs SHALL pass through cpu_addr, cpu_wdata and cpu_we combinationally; cpu_rdy=1; dma_active=0.
REQ-017 In IDLE, cpu_we=1 with cpu_addr==DMA_REG SHALL latch page=cpu_wdata, clear idx to 0 and enter HALT next cycle.
REQ-018 The trigger write itself SHALL reach the bus unmodified.
REQ-019 In every non-IDLE state: cpu_rdy=0, dma_active=1, and bus outputs come from the DMA only.
REQ-020 HALT and ALIGN SHALL drive bus_addr={page,8'h00} and bus_we=0.
REQ-021 HALT SHALL last one cycle; next state is ALIGN if parity in HALT is 0, else READ.
REQ-022 ALIGN SHALL last one cycle, then go to READ.
REQ-023 READ therefore SHALL always occur on parity-0 cycles.
REQ-024 READ SHALL drive bus_addr={page,idx} and bus_we=0, and capture bus_rdata into an 8-bit latch at the clock edge ending the cycle.
REQ-025 After READ, next state SHALL be WRITE.
REQ-026 WRITE SHALL drive bus_addr=OAM_DATA, bus_wdata=latch and bus_we=1.
REQ-027 WRITE SHALL then increment idx modulo 256.
REQ-028 After WRITE with idx==8'hFF, next state SHALL be IDLE, with cpu_rdy=1 on the following cycle; otherwise next state SHALL be READ.
REQ-029 Transfer length SHALL be exactly 256 bytes, ascending from {page,00} to {page,FF}; idx wrap to 0 SHALL coincide with the return to IDLE.
REQ-030 cpu_rdy low duration SHALL be 513 cycles without ALIGN and 514 cycles with ALIGN.
REQ-031 Writes to DMA_REG while not IDLE SHALL be ignored, with no retrigger and no change to page.
REQ-032 A CPU write to DMA_REG in the same cycle that the final WRITE completes SHALL NOT trigger a transfer; the CPU is halted in that cycle.
REQ-033 Writes to any other address in IDLE SHALL have no effect on DMA state.
REQ-034 page 8'hFF SHALL be legal and source from $FF00-$FFFF, the boot ROM region.

Reset
REQ-035 n_reset low SHALL immediately force: state IDLE, parity 0, page 0, idx 0, latch 0, cpu_rdy=1, dma_active=0, bus outputs in pass-through.
REQ-036 Reset asserted mid-transfer SHALL abort without further bus writes; after release, the block waits for a new trigger.

Verification
REQ-037 CPU writes 8'h02 to $4014 on a parity-0 cycle -> HALT then READ with no ALIGN; reads $0200-$02FF interleaved with 256 writes to $2004 carrying the same bytes in order; cpu_rdy low for 513 cycles.
REQ-038 Same trigger on a parity-1 cycle -> one ALIGN cycle inserted; cpu_rdy low for 514 cycles; first READ on parity 0.
REQ-039 page 8'hFF with boot ROM behind the bus -> the first $2004 write carries the ROM byte at $FF00; writes 253 and 254 carry 8'h00 and 8'hFF, the reset vector bytes.
REQ-040 During a transfer, the CPU model drives a write of 8'h05 to $4014 -> ignored; the source page stays the original; total length unchanged.
REQ-041 n_reset pulsed after the 100th $2004 write -> cpu_rdy=1 and dma_active=0 asynchronously; no further $2004 writes; a new trigger restarts from idx 0.
REQ-042 CPU writes to $2004 and $4015 in IDLE -> passed through to the bus; cpu_rdy stays 1; no transfer.
